// File: rtl/hci_reset_ctrl.sv
// HCI RESET_CONTROL servicing: drives core/queue resets from the self-clearing CSR bits,
// waits for per-queue completion and strobes the CSR bits back to 0.
module hci_reset_ctrl #(
  parameter int NUM_QUEUES      = 5,
  parameter int SOFT_RST_CYCLES = 16,
  parameter int ACK_TIMEOUT     = 255
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  soft_rst_req_i,
  input  logic [NUM_QUEUES-1:0] queue_rst_req_i,
  output logic [NUM_QUEUES-1:0] queue_rst_o,
  input  logic [NUM_QUEUES-1:0] queue_rst_done_i,
  output logic                  core_soft_rst_o,
  output logic                  soft_rst_clr_we_o,
  output logic [NUM_QUEUES-1:0] queue_rst_clr_we_o,
  output logic                  busy_o,
  output logic                  err_timeout_o,
  input  logic                  err_clr_i,
  output logic [2:0]            state_o
);

  localparam int MAX_CYC = (SOFT_RST_CYCLES > ACK_TIMEOUT) ? SOFT_RST_CYCLES : ACK_TIMEOUT;
  localparam int CW      = $clog2(MAX_CYC + 1);
  localparam logic [CW-1:0] SOFT_LOAD = CW'(SOFT_RST_CYCLES - 1);
  localparam logic [CW-1:0] ACK_LOAD  = CW'(ACK_TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    SOFT_ASSERT = 3'd1,
    WAIT_DONE   = 3'd2,
    CLEAR       = 3'd3,
    HOLDOFF     = 3'd4
  } state_e;

  state_e                  state_q, state_d;
  logic [NUM_QUEUES-1:0]   pending_q, pending_d;
  logic [NUM_QUEUES-1:0]   outstanding_q, outstanding_d;
  logic [NUM_QUEUES-1:0]   latched_q, latched_d;
  logic [NUM_QUEUES-1:0]   outstanding_masked;
  logic                    soft_flag_q, soft_flag_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic                    err_q;
  logic                    err_set;

  // Handshake: queue_rst_o[i] is a level request held until queue_rst_done_i[i] is
  // sampled high in WAIT_DONE; the request drops on the following cycle. Done is a
  // level that may already be high when the request rises and then counts at once.
  assign outstanding_masked = outstanding_q & ~queue_rst_done_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= IDLE;
      pending_q     <= '0;
      outstanding_q <= '0;
      latched_q     <= '0;
      soft_flag_q   <= 1'b0;
      cnt_q         <= '0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      pending_q     <= pending_d;
      outstanding_q <= outstanding_d;
      latched_q     <= latched_d;
      soft_flag_q   <= soft_flag_d;
      cnt_q         <= cnt_d;
      if (err_set) begin
        err_q <= 1'b1;
      end else if (err_clr_i) begin
        err_q <= 1'b0;
      end
    end
  end

  always_comb begin
    state_d            = state_q;
    pending_d          = pending_q;
    outstanding_d      = outstanding_q;
    latched_d          = latched_q;
    soft_flag_d        = soft_flag_q;
    cnt_d              = cnt_q;
    err_set            = 1'b0;
    queue_rst_o        = '0;
    core_soft_rst_o    = 1'b0;
    soft_rst_clr_we_o  = 1'b0;
    queue_rst_clr_we_o = '0;

    case (state_q)
      IDLE: begin
        if (soft_rst_req_i) begin
          // Queue bits set alongside soft reset are covered by it and cleared with it.
          pending_d   = '1;
          latched_d   = queue_rst_req_i;
          soft_flag_d = 1'b1;
          cnt_d       = SOFT_LOAD;
          state_d     = SOFT_ASSERT;
        end else if (|queue_rst_req_i) begin
          pending_d     = queue_rst_req_i;
          outstanding_d = queue_rst_req_i;
          latched_d     = '0;
          soft_flag_d   = 1'b0;
          cnt_d         = ACK_LOAD;
          state_d       = WAIT_DONE;
        end
      end

      SOFT_ASSERT: begin
        core_soft_rst_o = 1'b1;
        queue_rst_o     = '1;
        if (cnt_q == '0) begin
          cnt_d         = ACK_LOAD;
          outstanding_d = pending_q;
          state_d       = WAIT_DONE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end

      WAIT_DONE: begin
        queue_rst_o   = outstanding_q;
        outstanding_d = outstanding_masked;
        if (outstanding_masked == '0) begin
          state_d = CLEAR;
        end else if (cnt_q == '0) begin
          err_set       = 1'b1;
          outstanding_d = '0;
          state_d       = CLEAR;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end

      CLEAR: begin
        queue_rst_clr_we_o = soft_flag_q ? latched_q : pending_q;
        soft_rst_clr_we_o  = soft_flag_q;
        state_d            = HOLDOFF;
      end

      // One idle cycle lets the CSR write land before request levels are sampled again.
      HOLDOFF: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy_o        = (state_q != IDLE);
  assign err_timeout_o = err_q;
  assign state_o       = state_q;

endmodule

// File: tb/tb_hci_reset_ctrl.sv
// Directed bench for hci_reset_ctrl: emulates the CSR self-clear and checks reset
// sequencing, timeout, priority, async abort and back-to-back queue servicing.
module tb_hci_reset_ctrl;

  localparam int NQ = 5;

  logic          clk;
  logic          rst_n;
  logic          soft_req;
  logic [NQ-1:0] q_req;
  logic [NQ-1:0] q_rst;
  logic [NQ-1:0] q_done;
  logic          core_rst;
  logic          soft_clr;
  logic [NQ-1:0] q_clr;
  logic          busy;
  logic          err;
  logic          err_clr;
  logic [2:0]    state;

  int checks;
  int failures;
  logic [NQ:0] exp_q[$];

  hci_reset_ctrl #(
    .NUM_QUEUES(NQ), .SOFT_RST_CYCLES(16), .ACK_TIMEOUT(255)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .soft_rst_req_i(soft_req), .queue_rst_req_i(q_req),
    .queue_rst_o(q_rst), .queue_rst_done_i(q_done),
    .core_soft_rst_o(core_rst), .soft_rst_clr_we_o(soft_clr),
    .queue_rst_clr_we_o(q_clr), .busy_o(busy),
    .err_timeout_o(err), .err_clr_i(err_clr), .state_o(state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Advance one cycle, sample #1 after the edge, then let the CSR model apply any clear strobe.
  task automatic step();
    @(posedge clk);
    #1;
    if (soft_clr) soft_req = 1'b0;
    q_req = q_req & ~q_clr;
  endtask

  task automatic wait_clear(input string tag, input int bound);
    int n;
    logic [NQ:0] exp;
    n = 0;
    while (!(soft_clr || (|q_clr)) && n < bound) begin
      step();
      n++;
    end
    check({tag, "_seen"}, {31'd0, soft_clr || (|q_clr)}, 32'd1);
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    check({tag, "_clr"}, {26'd0, soft_clr, q_clr}, {26'd0, exp});
  endtask

  task automatic count_soft(input string tag);
    int cnt;
    cnt = 0;
    while (core_rst && cnt < 100) begin
      if (cnt == 0) check({tag, "_qrst_all"}, {27'd0, q_rst}, 32'h1f);
      cnt++;
      step();
    end
    check({tag, "_soft_cycles"}, cnt, 32'd16);
  endtask

  initial begin
    int cnt;
    checks = 0; failures = 0;
    rst_n = 1'b0; soft_req = 1'b0; q_req = '0; q_done = '0; err_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_outs", {24'd0, core_rst, soft_clr, q_rst, err}, 32'd0);
    check("rst_state", {29'd0, state}, 32'd0);
    rst_n = 1'b1;
    step();

    // single queue, done after three request cycles
    q_req = 5'b00010;
    cnt = 0;
    step();
    while (q_rst[1] && cnt < 20) begin
      cnt++;
      if (cnt == 3) q_done = 5'b00010;
      step();
    end
    check("q1_high_cycles", cnt, 32'd3);
    check("q1_clr", {27'd0, q_clr}, 32'h02);
    check("q1_soft_clr", {31'd0, soft_clr}, 32'd0);
    q_done = '0;
    step();
    check("q1_holdoff_busy", {31'd0, busy}, 32'd1);
    check("q1_holdoff_noclr", {27'd0, q_clr}, 32'd0);
    step();
    check("q1_idle_busy", {31'd0, busy}, 32'd0);
    check("q1_err", {31'd0, err}, 32'd0);

    // soft reset with all done tied high
    q_done = '1;
    soft_req = 1'b1;
    step();
    count_soft("soft");
    check("soft_wait_qrst", {27'd0, q_rst}, 32'h1f);
    exp_q.push_back({1'b1, 5'b00000});
    wait_clear("soft", 5);
    step(); step();
    check("soft_idle", {31'd0, busy}, 32'd0);

    // timeout: done[2] never returns
    q_done = 5'b00001;
    q_req = 5'b00101;
    step();
    check("to_w1_qrst", {27'd0, q_rst}, 32'h05);
    step();
    check("to_w2_qrst", {27'd0, q_rst}, 32'h04);
    cnt = 2;
    while (!(|q_clr) && cnt < 400) begin
      step();
      cnt++;
    end
    check("to_wait_cycles", cnt - 1, 32'd255);
    check("to_clr", {27'd0, q_clr}, 32'h05);
    check("to_err_set", {31'd0, err}, 32'd1);
    step(); step();
    check("to_err_sticky", {31'd0, err}, 32'd1);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    check("to_err_cleared", {31'd0, err}, 32'd0);

    // soft and all queue bits in the same cycle
    q_done = '1;
    soft_req = 1'b1;
    q_req = 5'b11111;
    step();
    check("both_core_rst", {31'd0, core_rst}, 32'd1);
    exp_q.push_back({1'b1, 5'b11111});
    wait_clear("both", 40);
    step(); step();

    // async reset during soft assert, then full restart
    soft_req = 1'b1;
    repeat (5) step();
    check("abort_pre_core", {31'd0, core_rst}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("abort_outs", {23'd0, busy, core_rst, soft_clr, q_rst, err}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("abort_req_kept", {31'd0, soft_req}, 32'd1);
    step();
    count_soft("restart");
    exp_q.push_back({1'b1, 5'b00000});
    wait_clear("restart", 5);
    step(); step();

    // queue 0 requested while queue 3 is in progress
    q_done = '0;
    q_req = 5'b01000;
    step();
    check("b2b_q3", {27'd0, q_rst}, 32'h08);
    q_req[0] = 1'b1;
    step(); step();
    check("b2b_q3_only", {27'd0, q_rst}, 32'h08);
    q_done = 5'b01000;
    exp_q.push_back({1'b0, 5'b01000});
    wait_clear("b2b_first", 3);
    q_done = '0;
    step();
    check("b2b_holdoff", {31'd0, busy}, 32'd1);
    step();
    check("b2b_idle", {31'd0, busy}, 32'd0);
    step();
    check("b2b_q0", {27'd0, q_rst}, 32'h01);
    q_done = 5'b00001;
    exp_q.push_back({1'b0, 5'b00001});
    wait_clear("b2b_second", 3);
    q_done = '0;
    step(); step();
    check("final_err", {31'd0, err}, 32'd0);
    check("final_req", {26'd0, soft_req, q_req}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
